// File: rtl/in_port_driver.sv
// Producer side of the CPU input-port handshake: synchronises and debounces a
// push-button and switch bank, latches the switches on each press and holds ready_out until acked.
module in_port_driver #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             cpu_ack,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             ready_out,
  output logic             overrun,
  output logic [3:0]       press_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync1;
  logic             btn_sync2;
  logic [WIDTH-1:0] sw_sync1;
  logic [WIDTH-1:0] sw_sync2;
  logic             btn_deb;
  logic [CNT_W-1:0] deb_cnt;

  logic             btn_deb_next;
  logic [CNT_W-1:0] deb_cnt_next;
  logic             press;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] data_next;
  logic             ready_next;
  logic             overrun_next;
  logic [3:0]       press_cnt_next;

  // Debouncer: the synchronised button must disagree for N consecutive edges to flip.
  always_comb begin
    btn_deb_next = btn_deb;
    deb_cnt_next = '0;
    if (btn_sync2 != btn_deb) begin
      if (deb_cnt == CNT_LAST) begin
        btn_deb_next = btn_sync2;
      end else begin
        deb_cnt_next = deb_cnt + CNT_W'(1);
      end
    end
  end

  assign press  = !btn_deb && btn_deb_next;
  assign accept = press && (!ready_out || cpu_ack);
  assign drop   = press && ready_out && !cpu_ack;

  // Handshake: a press either captures (freeing any pending word) or is dropped as overrun.
  always_comb begin
    data_next      = data_out;
    ready_next     = ready_out;
    overrun_next   = overrun;
    press_cnt_next = press_cnt;
    if (accept) begin
      data_next      = sw_sync2;
      ready_next     = 1'b1;
      press_cnt_next = press_cnt + 4'd1;
    end else if (ready_out && cpu_ack) begin
      ready_next = 1'b0;
    end
    if (drop) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
      btn_deb   <= 1'b0;
      deb_cnt   <= '0;
      data_out  <= '0;
      ready_out <= 1'b0;
      overrun   <= 1'b0;
      press_cnt <= 4'd0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      sw_sync1  <= sw_raw;
      sw_sync2  <= sw_sync1;
      btn_deb   <= btn_deb_next;
      deb_cnt   <= deb_cnt_next;
      data_out  <= data_next;
      ready_out <= ready_next;
      overrun   <= overrun_next;
      press_cnt <= press_cnt_next;
    end
  end

endmodule

// File: tb/tb_in_port_driver.sv
// Bench for in_port_driver: hand-built vector table, directed corner sequences,
// and random stimulus compared every cycle against a sliding-window reference model.
module tb_in_port_driver;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_raw;
  logic [WIDTH-1:0] sw_raw;
  logic             cpu_ack;
  logic             ovr_clr;
  logic [WIDTH-1:0] data_out;
  logic             ready_out;
  logic             overrun;
  logic [3:0]       press_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  in_port_driver #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .cpu_ack  (cpu_ack),
    .ovr_clr  (ovr_clr),
    .data_out (data_out),
    .ready_out(ready_out),
    .overrun  (overrun),
    .press_cnt(press_cnt)
  );

  // Reference model: two-stage input delay, then the debounced level flips once
  // the last N delayed samples all disagree with it.
  logic             m_b1 = 1'b0, m_b2 = 1'b0;
  logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0]     m_win = '0;
  logic             m_deb = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_rdy = 1'b0;
  logic             m_ovr = 1'b0;
  int               m_cnt = 0;

  task automatic model_edge(input logic r, input logic b, input logic [WIDTH-1:0] s,
                            input logic a, input logic c);
    logic pr;
    if (r) begin
      m_b1 = 0; m_b2 = 0; m_s1 = '0; m_s2 = '0; m_win = '0; m_deb = 0;
      m_data = '0; m_rdy = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      m_win = {m_win[N-2:0], m_b2};
      pr = !m_deb && (&m_win);
      if (pr) m_deb = 1'b1;
      else if (m_deb && !(|m_win)) m_deb = 1'b0;
      if (pr && m_rdy && !a) begin
        m_ovr = 1'b1;
      end else begin
        if (pr) begin
          m_data = m_s2; m_rdy = 1'b1; m_cnt = (m_cnt + 1) % 16;
        end else if (m_rdy && a) begin
          m_rdy = 1'b0;
        end
        if (c) m_ovr = 1'b0;
      end
      m_b2 = m_b1; m_b1 = b; m_s2 = m_s1; m_s1 = s;
    end
  endtask

  task automatic tick(input logic r, input logic b, input logic [WIDTH-1:0] s,
                      input logic a, input logic c);
    @(negedge clk);
    reset = r; btn_raw = b; sw_raw = s; cpu_ack = a; ovr_clr = c;
    @(posedge clk);
    model_edge(r, b, s, a, c);
    #1;
    vectors++;
    if ({data_out, ready_out, overrun, press_cnt} !== {m_data, m_rdy, m_ovr, 4'(m_cnt)}) begin
      miscompares++;
      $display("FAIL model t=%0t: got data=%h rdy=%b ovr=%b cnt=%0d, want data=%h rdy=%b ovr=%b cnt=%0d",
               $time, data_out, ready_out, overrun, press_cnt, m_data, m_rdy, m_ovr, m_cnt);
    end
  endtask

  task automatic check(input string name, input logic rdy, input logic [WIDTH-1:0] d,
                       input logic ovr, input logic [3:0] cnt);
    vectors++;
    if ({data_out, ready_out, overrun, press_cnt} !== {d, rdy, ovr, cnt}) begin
      miscompares++;
      $display("FAIL %s: got data=%h rdy=%b ovr=%b cnt=%0d, want data=%h rdy=%b ovr=%b cnt=%0d",
               name, data_out, ready_out, overrun, press_cnt, d, rdy, ovr, cnt);
    end
  endtask

  // Full press: hold the button until the debounced edge (6th tick), then release long enough to settle.
  task automatic press(input logic [WIDTH-1:0] s, input logic ack_at_event, input logic clr_at_event);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, s, (i == 5) ? ack_at_event : 1'b0, (i == 5) ? clr_at_event : 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, s, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic             rst;
    logic             btn;
    logic [WIDTH-1:0] sw;
    logic             ack;
    logic             clr;
    logic             rdy;
    logic [WIDTH-1:0] data;
    logic             ovr;
    logic [3:0]       cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic btn, input logic [WIDTH-1:0] sw,
                              input logic ack, input logic clr, input logic rdy,
                              input logic [WIDTH-1:0] data, input logic ovr, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.btn = btn; v.sw = sw; v.ack = ack; v.clr = clr;
    v.rdy = rdy; v.data = data; v.ovr = ovr; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic b;
    int   hold;
    reset = 1'b1; btn_raw = 1'b0; sw_raw = '0; cpu_ack = 1'b0; ovr_clr = 1'b0;

    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 0, 8'hA5, 0, 1));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 8'hA5, 0, 0, 0, 8'hA5, 0, 1));
    tbl.push_back(mk(0, 0, 8'hA5, 1, 0, 0, 8'hA5, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 8'hA5, 0, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 8'h11, 0, 0, 0, 8'hA5, 0, 1));

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].btn, tbl[i].sw, tbl[i].ack, tbl[i].clr);
      check($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].data, tbl[i].ovr, tbl[i].cnt);
    end

    press(8'hA5, 1'b0, 1'b0);
    check("second_capture", 1'b1, 8'hA5, 1'b0, 4'd2);
    press(8'h3C, 1'b0, 1'b0);
    check("overrun_set", 1'b1, 8'hA5, 1'b1, 4'd2);
    tick(1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    check("overrun_clr", 1'b1, 8'hA5, 1'b0, 4'd2);
    press(8'h77, 1'b0, 1'b1);
    check("set_beats_clr", 1'b1, 8'hA5, 1'b1, 4'd2);
    tick(1'b0, 1'b0, 8'h77, 1'b0, 1'b1);
    press(8'h5A, 1'b1, 1'b0);
    check("ack_with_press", 1'b1, 8'h5A, 1'b0, 4'd3);

    for (int i = 0; i < 12; i++) press(8'(i + 8'h40), 1'b1, 1'b0);
    check("cnt_15", 1'b1, 8'h4B, 1'b0, 4'd15);
    press(8'hC1, 1'b1, 1'b0);
    check("cnt_wrap", 1'b1, 8'hC1, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) press(8'(i + 8'h80), 1'b1, 1'b0);
    check("cnt_wrap_15", 1'b1, 8'h8E, 1'b0, 4'd15);

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hE7, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'hE7, 1'b0, 1'b0);
    check("reset_mid_debounce", 1'b0, 8'h00, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'hE7, 1'b0, 1'b0);
    check("held_no_early", 1'b0, 8'h00, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 8'hE7, 1'b0, 1'b0);
    check("held_through_reset", 1'b1, 8'hE7, 1'b0, 4'd1);

    b = 1'b0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        b = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 10));
      end
      hold--;
      tick(1'($urandom_range(0, 199) == 0), b, 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
